// File: rtl/adsb_pkg.sv
// Shared types and constants for the ADS-B Mode S frame demodulator.
package adsb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_DATA
   } state_t;

   localparam int SHORT_BITS = 56;
   localparam int LONG_BITS  = 112;

   // Chip pattern of the 8 us Mode S preamble, first chip in the MSB
   localparam logic [15:0] PREAMBLE_DEFAULT = 16'b1010000101000000;

   // Received bit index that carries DF[4]; a 1 there selects a long frame
   localparam int DF_LONG_BIT = 0;

   // Index of the final byte for a frame of the given length
   function automatic logic [3:0] last_byte_index(input logic is_long);
      return is_long ? 4'(LONG_BITS / 8 - 1) : 4'(SHORT_BITS / 8 - 1);
   endfunction

endpackage

// File: rtl/adsb_frame_demod_if.sv
// Byte stream from the demodulator to the host-side transport.
interface adsb_frame_demod_if;

   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_first;
   logic       out_last;

   modport master (
      output out_data,
      output out_valid,
      output out_first,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      input  out_first,
      input  out_last,
      output out_ready
   );

endinterface

// File: rtl/adsb_byte_packer.sv
// Packs decoded bits MSB-first into bytes, tags first/last and holds one
// byte for the valid/ready consumer. A byte that completes while the holding
// register is still occupied is dropped and flagged as an overrun.
module adsb_byte_packer
   import adsb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       bit_push,
   input  logic       bit_val,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   output logic       out_first,
   output logic       out_last,
   output logic       overrun,
   output logic       byte_drop,
   output logic       frame_done
);

   logic [6:0] shift;
   logic [2:0] bit_cnt;
   logic [3:0] byte_idx;
   logic       long_frame;
   logic       byte_done;

   assign byte_done  = bit_push && (bit_cnt == 3'd7);
   assign byte_drop  = byte_done && out_valid && !out_ready;
   assign frame_done = byte_done && (byte_idx == last_byte_index(long_frame));

   // Shift register, byte counter and the single-entry holding register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift      <= '0;
         bit_cnt    <= '0;
         byte_idx   <= '0;
         long_frame <= 1'b0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         out_first  <= 1'b0;
         out_last   <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (start) begin
            bit_cnt  <= '0;
            byte_idx <= '0;
         end else if (bit_push) begin
            if ((byte_idx == 4'd0) && (bit_cnt == 3'(DF_LONG_BIT))) begin
               long_frame <= bit_val;
            end
            shift   <= {shift[5:0], bit_val};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               byte_idx <= byte_idx + 4'd1;
               if (byte_drop) begin
                  overrun <= 1'b1;
               end else begin
                  out_data  <= {shift, bit_val};
                  out_valid <= 1'b1;
                  out_first <= (byte_idx == 4'd0);
                  out_last  <= (byte_idx == last_byte_index(long_frame));
               end
            end
         end
      end
   end

endmodule

// File: rtl/adsb_frame_demod.sv
// Mode S preamble detector and Manchester frame decoder. The sliced RF input
// is synchronised, the preamble is matched chip by chip at mid-chip, then
// 56- or 112-bit frames are decoded and handed to the byte packer.
module adsb_frame_demod
   import adsb_pkg::*;
#(
   parameter int          OVS      = 8,
   parameter int          MAX_ERR  = 3,
   parameter logic [15:0] PREAMBLE = PREAMBLE_DEFAULT,
   parameter int          ERRW     = $clog2(MAX_ERR + 2)
) (
   input  logic                clk8M,
   input  logic                rst,
   input  logic                adsb_in,
   adsb_frame_demod_if.master  out_if,
   output logic                frame_ok,
   output logic                frame_abort,
   output logic                overrun,
   output logic [ERRW-1:0]     bit_err_count,
   output logic                busy
);

   localparam int HALF = OVS / 2;
   localparam int PW   = $clog2(HALF);

   logic [2:0]    sync;
   state_t        state;
   logic [PW-1:0] phase;
   logic [3:0]    chip_idx;
   logic          second_chip;
   logic          first_chip;

   logic rise;
   logic chip_tick;
   logic chip_val;
   logic is_violation;
   logic err_limit;
   logic bit_push;
   logic bit_val;
   logic pk_start;
   logic byte_drop;
   logic frame_done;

   // The third flop lines chip samples up with the phase counter restart
   assign rise         = sync[1] && !sync[2];
   assign chip_val     = sync[2];
   assign chip_tick    = (phase == PW'(OVS / 4));
   assign is_violation = (first_chip == chip_val);
   assign err_limit    = is_violation && (bit_err_count == ERRW'(MAX_ERR));
   assign bit_val      = first_chip && !chip_val;
   assign bit_push     = (state == ST_DATA) && chip_tick && second_chip && !err_limit;
   assign pk_start     = (state == ST_PREAMBLE) && chip_tick && (chip_idx == 4'd0)
                         && (chip_val == PREAMBLE[chip_idx]);
   assign busy         = (state != ST_IDLE);

   // Two-flop synchroniser plus an edge-detect flop for the async input
   always_ff @(posedge clk8M or posedge rst) begin
      if (rst) begin
         sync <= '0;
      end else begin
         sync <= {sync[1:0], adsb_in};
      end
   end

   // Chip phase counter, realigned to the edge that starts a preamble
   always_ff @(posedge clk8M or posedge rst) begin
      if (rst) begin
         phase <= '0;
      end else if ((state == ST_IDLE) && rise) begin
         phase <= '0;
      end else if (phase == PW'(HALF - 1)) begin
         phase <= '0;
      end else begin
         phase <= phase + 1'b1;
      end
   end

   // Frame FSM: preamble matching, Manchester bit decisions, error policy
   always_ff @(posedge clk8M or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         chip_idx      <= '0;
         second_chip   <= 1'b0;
         first_chip    <= 1'b0;
         bit_err_count <= '0;
         frame_ok      <= 1'b0;
         frame_abort   <= 1'b0;
      end else begin
         frame_ok    <= 1'b0;
         frame_abort <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (rise) begin
                  state    <= ST_PREAMBLE;
                  chip_idx <= 4'd15;
               end
            end
            ST_PREAMBLE: begin
               if (chip_tick) begin
                  if (chip_val != PREAMBLE[chip_idx]) begin
                     state <= ST_IDLE;
                  end else if (chip_idx == 4'd0) begin
                     state         <= ST_DATA;
                     second_chip   <= 1'b0;
                     bit_err_count <= '0;
                  end else begin
                     chip_idx <= chip_idx - 4'd1;
                  end
               end
            end
            ST_DATA: begin
               if (chip_tick) begin
                  if (!second_chip) begin
                     first_chip  <= chip_val;
                     second_chip <= 1'b1;
                  end else begin
                     second_chip <= 1'b0;
                     if (is_violation) begin
                        bit_err_count <= bit_err_count + 1'b1;
                     end
                     if (err_limit || byte_drop) begin
                        frame_abort <= 1'b1;
                        state       <= ST_IDLE;
                     end else if (frame_done) begin
                        frame_ok <= 1'b1;
                        state    <= ST_IDLE;
                     end
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   adsb_byte_packer u_packer (
      .clk        (clk8M),
      .rst        (rst),
      .start      (pk_start),
      .bit_push   (bit_push),
      .bit_val    (bit_val),
      .out_ready  (out_if.out_ready),
      .out_data   (out_if.out_data),
      .out_valid  (out_if.out_valid),
      .out_first  (out_if.out_first),
      .out_last   (out_if.out_last),
      .overrun    (overrun),
      .byte_drop  (byte_drop),
      .frame_done (frame_done)
   );

endmodule

// File: doc/adsb_frame_demod.md
Name: adsb_frame_demod

Overview:
- Parametrised successor to the team's ADS-B preamble detector / Manchester decoder.
- Takes the comparator output of the RF front end, oversampled at OVS clocks per 1 us bit.
- Detects the 8 us Mode S preamble, decodes 56- or 112-bit frames (length chosen from the DF field) and emits MSB-first bytes on a valid/ready stream with first/last markers and per-frame status.
- Sits between the analogue slicer and the SPI or host-side byte transport.

Parameters:
- OVS, 8, clocks per data bit; multiple of 4, >= 4; chip (half-bit) period = OVS/2 clocks.
- MAX_ERR, 3, Manchester violations tolerated per frame; a frame with more is aborted.
- PREAMBLE, 16'b1010000101000000, expected chip values, MSB first, one per 0.5 us chip.
- ERRW, $clog2(MAX_ERR+2), width of the error counter.

Ports:
- clk8M  in  1  sample clock (OVS x bit rate).
- rst  in  1  reset, asynchronous, active-high.
- adsb_in  in  1  sliced RF input, asynchronous to clk8M.
- out_data  out  8  decoded byte, MSB = earliest bit.
- out_valid  out  1  out_data holds a byte.
- out_ready  in  1  consumer accepts the byte when out_valid && out_ready.
- out_first  out  1  qualifies out_data: first byte of the frame.
- out_last  out  1  qualifies out_data: final byte of the frame.
- frame_ok  out  1  one-cycle pulse when a frame completes.
- frame_abort  out  1  one-cycle pulse when a frame is abandoned (errors or overrun).
- overrun  out  1  sticky; set when a byte is lost; cleared only by rst.
- bit_err_count  out  ERRW  violations in the current or most recent frame.
- busy  out  1  high in PREAMBLE or DATA.

Behaviour:
- Reset values: all outputs 0. State IDLE. Counters 0. Synchroniser flops 0.
- Input path: 2-flop synchroniser, then a third flop for edge detect. A rising edge is synced[1] && !synced[2].
- Phase counter, 0..OVS/2-1, restarts on the preamble edge. The chip sample is taken when phase == OVS/4 (mid-chip).
- FSM states:
  - IDLE: rising edge -> PREAMBLE, chip index 15, phase 0.
  - PREAMBLE: each chip sample is compared with PREAMBLE[idx].
    - Mismatch -> IDLE. The same cycle does not re-arm; the next rising edge does.
    - Match at idx 0 -> DATA, bit count 0, err count 0.
    - Edges seen inside PREAMBLE are ignored.
  - DATA: bit value is decided at the second chip sample of each bit.
    - 10 -> 1; 01 -> 0.
    - 00 or 11 -> violation: shift in 0, increment bit_err_count (saturating).
    - When the count would exceed MAX_ERR -> frame_abort, go to IDLE.
    - After bit 5, frame length is fixed: DF[4]=1 (first bit) gives 112, else 56.
    - After the last bit -> frame_ok pulse on the cycle after the final byte is written to the holding register, then IDLE.
    - Edges are ignored in DATA.
- Byte packing: bits shift into an 8-bit register. On the 8th bit the byte moves to the holding register next cycle.
  - out_first is set for byte 0; out_last is set for byte 6 or 13.
  - Latency is 1 clock from the deciding chip sample to out_valid.
- Handshake:
  - out_valid holds, and out_data/out_first/out_last stay stable, until out_ready.
  - A transfer and a new load in the same cycle is legal: the new byte wins and out_valid stays high.
  - If the holding register is still full when the next byte completes, the new byte is dropped, overrun is set and frame_abort pulses. The FSM returns to IDLE, but the held byte is still delivered.
- Abort semantics: the consumer discards bytes since the last out_first that were not followed by out_last.
- Simultaneous frame_ok and overrun cannot occur: overrun forces the abort path.
- bit_err_count holds its final value until the next DATA entry.
- Asynchronous rst mid-frame: immediate return to IDLE, out_valid 0, no pulses.

Decomposition:
- Shared package adsb_pkg holds:
  - state enum {IDLE, PREAMBLE, DATA};
  - constants SHORT_BITS=56, LONG_BITS=112;
  - default PREAMBLE;
  - DF_LONG_BIT index (0, first received bit).
- One natural sub-module, adsb_byte_packer. It contains the shift register, bit counter, holding register, valid/ready logic, first/last tagging and overrun detection.

Test Plan:
- DF17 frame 0x8D4840D6202CC371C32CE0576098 with clean preamble, out_ready=1 -> 14 bytes. 0x8D has out_first, 0x98 has out_last; frame_ok once; bit_err_count=0.
- Short frame bytes 0x5D,0x48,0x40,0xD6,0x11,0x22,0x33 -> exactly 7 bytes, out_last on 0x33, FSM IDLE afterwards.
- Preamble with chip 3 forced high -> no out_valid, no pulses, busy drops mid-preamble. A valid preamble 2 us later is decoded normally.
- DF17 frame with 3 bits forced to "11" -> frame_ok, bit_err_count=3, errored bits read 0. Repeat with 4 errored bits -> frame_abort at the 4th; no out_last.
- out_ready held 0 for 2*8*OVS cycles after first byte -> first byte 0x8D held stable, overrun=1, frame_abort pulse. 0x8D is delivered when out_ready rises.
- rst asserted for 1 cycle at bit 40 of a long frame -> all outputs 0 asynchronously. A following frame decodes correctly.
